// File: rtl/magnetron_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : magnetron_timer
// Description : Magnetron on/off SR register plus a BCD mm:ss cooking-time
//               countdown that raises timer_done at 00:00.
// Revision    : 1.0 - initial release
// ============================================================================
module magnetron_timer #(
  parameter int CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       set,
  input  logic       reset,
  input  logic       clearn,
  input  logic       loadn,
  input  logic [3:0] data,
  output logic       mag_on,
  output logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic          mag_on_q,   mag_on_d;
  logic [PW-1:0] presc_q,    presc_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    sec_ones_q, sec_ones_d;

  logic zero_w;
  logic counting_w;
  logic tick_w;
  logic load_ok_w;

  assign zero_w     = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                      (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
  assign counting_w = mag_on_q && !zero_w;
  assign tick_w     = counting_w && (presc_q == PRESC_MAX);
  assign load_ok_w  = !loadn && !mag_on_q && (data <= 4'd9);

  // Reset dominates set; set cannot start the magnetron with no time left.
  always_comb begin
    mag_on_d = mag_on_q;
    if (reset)
      mag_on_d = 1'b0;
    else if (set && !zero_w)
      mag_on_d = 1'b1;
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (!counting_w || reset || tick_w)
      presc_d = '0;
  end

  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (!clearn) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (load_ok_w) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = data;
    end else if (tick_w) begin
      // Borrow ripples upward; a tick never happens at 00:00.
      if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else begin
        sec_ones_d = 4'd9;
        if (sec_tens_q != 4'd0) begin
          sec_tens_d = sec_tens_q - 4'd1;
        end else begin
          sec_tens_d = 4'd5;
          if (min_ones_q != 4'd0) begin
            min_ones_d = min_ones_q - 4'd1;
          end else begin
            min_ones_d = 4'd9;
            min_tens_d = min_tens_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mag_on_q   <= 1'b0;
      presc_q    <= '0;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      mag_on_q   <= mag_on_d;
      presc_q    <= presc_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign mag_on     = mag_on_q;
  assign timer_done = zero_w;
  assign min_tens   = min_tens_q;
  assign min_ones   = min_ones_q;
  assign sec_tens   = sec_tens_q;
  assign sec_ones   = sec_ones_q;

endmodule
`default_nettype wire

// File: doc/magnetron_timer.md
Name: magnetron_timer

Overview:
Consumer end of the on/off control interface. It takes the set/reset pulses from on_off_logic and holds the magnetron state. It also runs a BCD mm:ss cooking-time countdown while the magnetron is on, and returns timer_done so on_off_logic can shut the oven off. It sits between on_off_logic and the 7-segment display/keypad path of the microwave top level.

Parameters:
CLK_DIV, 50000000, clk cycles per 1-second countdown tick; the bench uses 4.

Ports:
clk  input  1  system clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
set  input  1  turn-on request from on_off_logic, active high, level-sampled each cycle
reset  input  1  turn-off request from on_off_logic, active high, level-sampled each cycle
clearn  input  1  synchronous active-low clear of time digits (keypad CLEAR)
loadn  input  1  synchronous active-low digit-entry strobe, one digit per low cycle
data  input  4  BCD keypad digit entered on loadn
mag_on  output  1  magnetron enable (registered)
timer_done  output  1  high when all four time digits are zero (combinational from registers)
min_tens  output  4  BCD minutes tens (registered)
min_ones  output  4  BCD minutes ones (registered)
sec_tens  output  4  BCD seconds tens, range 0-5 (registered)
sec_ones  output  4  BCD seconds ones (registered)

Behaviour:
- Reset (rstn=0, asynchronous): mag_on=0, all digits=0 (so timer_done=1), prescaler=0.
- mag_on SR register:
  - reset=1 → mag_on←0. Reset dominates when set and reset are both 1.
  - set=1 with reset=0 and timer_done=0 → mag_on←1.
  - set=1 with timer_done=1 is ignored; mag_on stays 0.
  - Otherwise mag_on holds.
- Digit priority per cycle: clearn > load > countdown.
- clearn=0: all digits←0 next edge, regardless of mag_on. mag_on is not changed by this block; the shutdown comes through timer_done/on_off_logic.
- Load (loadn=0, clearn=1, mag_on=0, data≤9): shift left one digit. min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←data.
  - Ignored if mag_on=1 or data>9.
  - Entered values are not range-checked beyond BCD. For example, sec_tens may receive 6-9 by entry; countdown borrow still reloads 5.
- Prescaler:
  - Counts 0..CLK_DIV-1 only while mag_on=1 and timer_done=0.
  - Forced to 0 whenever mag_on=0.
  - Tick occurs in the cycle where prescaler==CLK_DIV-1; the prescaler then wraps to 0.
  - The first decrement occurs CLK_DIV cycles after mag_on rises.
- Countdown on tick, BCD with borrow chain:
  - sec_ones 0→9 with borrow, else −1.
  - On borrow: sec_tens 0→5 with borrow, else −1.
  - On borrow: min_ones 0→9 with borrow, else −1.
  - On borrow: min_tens −1.
  - A tick never occurs at 00:00, so there is no wrap past zero.
- timer_done rises in the same cycle the digits become 00:00. mag_on stays 1 until reset arrives from on_off_logic; while at 00:00 the prescaler is held at 0.
- reset mid-count: mag_on←0 and the prescaler clears. Digits hold the remaining time; a later set resumes from the held value.
- loadn low while counting has no effect.
- clearn low while counting zeroes the digits, and timer_done rises the next cycle.

Test Plan (CLK_DIV=4):
1. Reset release → mag_on=0, digits 00:00, timer_done=1. Pulse set with no time loaded → mag_on stays 0.
2. Load digits 0,1,0,5 (four loadn cycles) → display 01:05, timer_done=0. Pulse set → mag_on=1 next edge. After 4 cycles display 01:04; after 24 cycles total display 00:59 (borrow through min_ones and sec_tens).
3. Load 00:02, set → 00:01 at 4 cycles, 00:00 at 8 cycles, timer_done=1 that cycle. Counting stops. Assert reset → mag_on=0.
4. Load 00:09, set, wait 8 cycles (00:07). Assert reset → mag_on=0 and digits hold 00:07 for 20 cycles. Set again → 00:06 after 4 more cycles.
5. set and reset high in the same cycle with time 00:05 → mag_on=0. Loadn with data=7 while mag_on=1 → digits unchanged. Data=12 with mag_on=0 → digits unchanged.
6. Counting from 00:30, pull clearn low for one cycle → 00:00, timer_done=1. Assert rstn low mid-prescaler → outputs return to reset values immediately (asynchronously).
